// File: rtl/wb_ctrl.sv
// Writeback controller: accepts PC/ALU/MEM writeback requests and issues one register-file write each.
// Optional WB_TIMEOUT_EN adds a load-wait watchdog that aborts the request and pulses wb_err_o.
module wb_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  logic [1:0]            wb_src_i,
    input  logic [4:0]            wb_rd_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] alu_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  flush_i,
    output logic [1:0]            which_mux_o,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  wb_done_o,
    output logic                  wb_err_o
);

    localparam logic [1:0] SRC_PC   = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_MEM  = 2'b10;
    localparam logic [1:0] SRC_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } state_t;

    state_t state;

    // The timeout counter is 8 bits wide, so TIMEOUT must fit in 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_ctrl: TIMEOUT must be in 1..255");
    end

    assign wb_ready_o = (state == IDLE);

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt;
`else
    assign wb_err_o = 1'b0;
`endif

    // Write outputs are registered together with the transition into WRITE,
    // so they are valid during exactly the one WRITE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rf_we_o     <= 1'b0;
            wb_done_o   <= 1'b0;
            which_mux_o <= 2'b00;
            rf_waddr_o  <= 5'd0;
            rf_wdata_o  <= '0;
`ifdef WB_TIMEOUT_EN
            wb_err_o    <= 1'b0;
            tmo_cnt     <= 8'd0;
`endif
        end else begin
            rf_we_o   <= 1'b0;
            wb_done_o <= 1'b0;
`ifdef WB_TIMEOUT_EN
            wb_err_o  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (wb_valid_i) begin
                        which_mux_o <= wb_src_i;
                        rf_waddr_o  <= wb_rd_i;
                        if (wb_src_i == SRC_MEM) begin
                            state <= WAIT_MEM;
`ifdef WB_TIMEOUT_EN
                            tmo_cnt <= 8'd0;
`endif
                        end else begin
                            state     <= WRITE;
                            wb_done_o <= 1'b1;
                            rf_we_o   <= (wb_rd_i != 5'd0) && (wb_src_i != SRC_NONE);
                            case (wb_src_i)
                                SRC_PC:  rf_wdata_o <= pc_i;
                                SRC_ALU: rf_wdata_o <= alu_i;
                                default: rf_wdata_o <= '0;
                            endcase
                        end
                    end
                end
                WAIT_MEM: begin
                    // Flush has priority over a coincident mem_valid_i.
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (mem_valid_i) begin
                        state      <= WRITE;
                        wb_done_o  <= 1'b1;
                        rf_we_o    <= (rf_waddr_o != 5'd0);
                        rf_wdata_o <= mem_data_i;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state    <= IDLE;
                        wb_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= 8'(tmo_cnt + 8'd1);
                    end
`endif
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, datapath width; TIMEOUT, default 255, memory-wait limit in cycles (8-bit counter).
REQ-002 Ports SHALL be, in order:
  clk_i  in  1  clock, all state on rising edge.
  rst_i  in  1  reset, synchronous, active-high.
  wb_valid_i  in  1  writeback request valid.
  wb_ready_o  out  1  controller can accept a request.
  wb_src_i  in  2  source: 00 PC, 01 ALU, 10 MEM, 11 none.
  wb_rd_i  in  5  destination register index.
  pc_i  in  DATA_WIDTH  link value (PC+4).
  alu_i  in  DATA_WIDTH  ALU result.
  mem_valid_i  in  1  load data valid.
  mem_data_i  in  DATA_WIDTH  load data.
  flush_i  in  1  abort the outstanding request.
  which_mux_o  out  2  select for the register writeback mux.
  rf_we_o  out  1  register-file write enable.
  rf_waddr_o  out  5  register-file write address.
  rf_wdata_o  out  DATA_WIDTH  register-file write data.
  wb_done_o  out  1  one-cycle completion pulse.
  wb_err_o  out  1  one-cycle timeout pulse (see Configuration).

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_MEM, WRITE.
REQ-004 wb_ready_o SHALL equal 1 only in IDLE, decoded combinationally from state.
REQ-005 The block SHALL accept a request when wb_valid_i and wb_ready_o are both 1, latching src, rd, pc_i and alu_i.
REQ-006 On accept, src 00/01/11 SHALL go to WRITE and src 10 SHALL go to WAIT_MEM.
REQ-007 In WAIT_MEM, mem_valid_i=1 SHALL latch mem_data_i and go to WRITE; mem_valid_i outside WAIT_MEM SHALL be ignored.
REQ-008 WRITE SHALL last exactly one cycle, assert wb_done_o=1, and then return to IDLE.
REQ-009 In WRITE, rf_we_o SHALL be 1 when rd!=0 and src!=11, otherwise 0.
REQ-010 In WRITE, rf_wdata_o SHALL be latched PC for 00, ALU for 01, memory data for 10, and 0 for 11.
REQ-011 rf_waddr_o and which_mux_o SHALL hold the latched rd and src from accept until the next accept.
REQ-012 Outside WRITE, rf_we_o and wb_done_o SHALL be 0.
REQ-013 Latency: a PC/ALU request accepted in cycle T SHALL write in T+1; for a MEM request, mem_valid_i in cycle M SHALL write in M+1.
REQ-014 Back-to-back requests: after WRITE in cycle T+1, the next accept SHALL be possible in T+2, giving 1 request per 2 cycles.
REQ-015 flush_i in WAIT_MEM SHALL return the FSM to IDLE with no write, no wb_done_o and no wb_err_o; when flush_i and mem_valid_i coincide, flush SHALL win.
REQ-016 flush_i in IDLE or WRITE SHALL have no effect; a WRITE in progress always completes.

Reset
REQ-017 While rst_i=1 at a clock edge: state SHALL be IDLE; rf_we_o, wb_done_o, wb_err_o SHALL be 0; which_mux_o, rf_waddr_o, rf_wdata_o SHALL be 0; the timeout counter SHALL be 0.
REQ-018 Reset in WAIT_MEM or WRITE SHALL abort the request with no write.
REQ-019 wb_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Configuration
REQ-020 With WB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_MEM and increment each cycle in WAIT_MEM.
REQ-021 With WB_TIMEOUT_EN defined, when the counter reaches TIMEOUT without mem_valid_i, the FSM SHALL go to IDLE, pulse wb_err_o for 1 cycle, and perform no write.
REQ-022 With WB_TIMEOUT_EN undefined, WAIT_MEM SHALL wait indefinitely, there SHALL be no counter, and wb_err_o SHALL be constant 0.

Verification
REQ-023 ALU request: src=01, rd=5, alu=0x1234 accepted in T -> in T+1 rf_we=1, waddr=5, wdata=0x1234, which_mux=01, done=1.
REQ-024 Load: src=10, rd=7, mem_valid 3 cycles later with data 0xDEADBEEF -> exactly one write of 0xDEADBEEF to x7 one cycle after mem_valid; wb_ready=0 throughout the wait.
REQ-025 x0 and none: src=00, rd=0, pc=0x80000004 -> done=1, rf_we=0; src=11, rd=3 -> done=1, rf_we=0, wdata=0.
REQ-026 Flush: load pending, flush_i and mem_valid_i high in the same cycle -> no write, no done, IDLE next cycle.
REQ-027 Timeout (WB_TIMEOUT_EN, TIMEOUT=4): load with no mem_valid -> wb_err pulse after 4 WAIT_MEM cycles, no write; without the macro, the block stays in WAIT_MEM for more than 300 cycles.
REQ-028 Reset mid-load: rst_i high for 1 cycle in WAIT_MEM -> all outputs 0, wb_ready=1 next cycle, and a later mem_valid is ignored.
